ysyx_24110015_mem_master: RTL and testbench
===========================================

# ysyx_24110015_mem_master

Initiator side of the core's simple valid-level memory interface. Accepts one load or store at a time from the LSU/fetch pipeline through a valid/ready request port and drives the memory's ren/wen request lines. It holds each request until rvalid/bvalid returns, then hands back sign- or zero-extended load data, or store completion, through a valid/ready response port. It also handles byte-lane alignment, misaligned-access rejection and a no-response timeout.

## Interface
- TIMEOUT, 255: cycles in READ/WRITE without a memory response before forcing an error response.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- resp_valid  out  1  response valid.
- resp_ready  in  1  CPU accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, nonzero rresp/bresp, or timeout.
- araddr  out  32  read address, word-aligned ({addr[31:2],2'b00}).
- ren  out  1  read request level.
- rdata  in  32  memory read word.
- rresp  in  2  read response (0 = OKAY).
- rvalid  in  1  read data valid.
- awaddr  out  32  write address, word-aligned.
- wdata  out  32  lane-shifted store data.
- wen  out  1  write request level.
- wstrb  out  4  byte strobes.
- bresp  in  2  write response (0 = OKAY).
- bvalid  in  1  write done.

## Operation
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- Reset values: state IDLE; ren, wen, resp_valid and resp_err 0; araddr, awaddr, wdata, wstrb and resp_rdata 0; timeout counter 0.
- IDLE: req_ready=1. On req_valid, latch addr[1:0], size, unsigned and wen, then check alignment:
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - Misaligned: go to DONE with resp_err=1 and resp_rdata=0. No memory request is issued.
  - Aligned load: go to READ with ren=1 and araddr set.
  - Aligned store: go to WRITE with wen=1, awaddr set, wdata=req_wdata<<(8*addr[1:0]), and wstrb = (byte 4'b0001, half 4'b0011, word 4'b1111) << addr[1:0].
- READ: hold ren and araddr stable and ignore bvalid.
  - On rvalid: ren←0 and go to DONE. Extract lane (rdata >> 8*off), extend to 32 bits per size and unsigned, and set resp_err=(rresp!=0).
- WRITE: hold wen, awaddr, wdata and wstrb stable and ignore rvalid.
  - On bvalid: wen←0 and go to DONE with resp_err=(bresp!=0) and resp_rdata=0.
- Timeout: the counter clears on entry to READ/WRITE and increments each cycle there.
  - When it reaches TIMEOUT with no response: drop ren/wen and go to DONE with resp_err=1 and resp_rdata=0.
  - If a response arrives in the same cycle the counter reaches TIMEOUT, the response wins.
- DONE: resp_valid=1, and ren=wen=0, which lets the memory clear its rvalid/bvalid. Hold resp_rdata and resp_err stable until resp_valid & resp_ready, then go to IDLE with resp_valid←0.
- Reset mid-operation returns everything to reset values immediately. An in-flight request is abandoned and no response is produced.

## Timing
- Acceptance edge E0: ren/wen high after E0.
- With a memory of D-cycle delay, rvalid/bvalid is seen D cycles later. resp_valid rises one edge after that, so D+1 cycles after E0 (6 for D=5).
- Misaligned: resp_valid rises at E0+1.
- Minimum spacing: DONE plus IDLE guarantees at least one idle cycle between consecutive memory requests. ren/wen are never asserted while the previous rvalid/bvalid is still high.
- Single outstanding transaction. req_ready is 0 from E0 until the cycle after the response handshake.

## Test plan
- Word load, addr 0x80000004, memory word 0x8899AABB, resp_ready=1 → ren high 5 cycles, resp_valid at E0+6, resp_rdata=0x8899AABB, resp_err=0, ren low in DONE.
- Byte loads from the same word: signed off 3 → 0xFFFFFF88; unsigned off 3 → 0x00000088; signed half off 2 → 0xFFFF8899; signed byte off 0 → 0xFFFFFFBB.
- Store byte 0x000000CD at addr 0x80000002 → wstrb=4'b0100, wdata=0x00CD0000, awaddr=0x80000000, resp_err=0, resp_rdata=0.
- Misaligned word load at 0x80000001 → no ren or wen ever asserted, resp_valid at E0+1 with resp_err=1.
- Memory never responds, TIMEOUT=8 → ren drops and resp_valid=1, resp_err=1 after 8 cycles in READ. A separate case with rresp=2 → resp_err=1.
- Back-to-back loads with resp_ready held low 3 cycles → resp_rdata and resp_err stable, req_ready=0 throughout, second ren rises only after one idle cycle. Reset asserted mid-READ → ren=0 immediately and no resp_valid after reset release.

Source files
------------

// File: rtl/ysyx_24110015_mem_master.sv
// Initiator for the core's valid-level memory interface: one load/store at a time,
// with lane alignment, sign/zero extension, misalignment rejection and a response timeout.
module ysyx_24110015_mem_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        ren,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic [31:0] awaddr,
  output logic [31:0] wdata,
  output logic        wen,
  output logic [3:0]  wstrb,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              misalign_c;
  logic [3:0]        strb_c;
  logic [31:0]       lane_c;
  logic [31:0]       ext_c;
  logic              timeout_hit_c;

  // Request decode: alignment check and strobe pattern for the incoming request
  always_comb begin
    misalign_c = 1'b0;
    strb_c     = 4'b1111;
    case (req_size)
      2'd0: begin
        misalign_c = 1'b0;
        strb_c     = 4'b0001;
      end
      2'd1: begin
        misalign_c = req_addr[0];
        strb_c     = 4'b0011;
      end
      2'd2: begin
        misalign_c = (req_addr[1:0] != 2'b00);
        strb_c     = 4'b1111;
      end
      default: begin
        misalign_c = 1'b1;
        strb_c     = 4'b1111;
      end
    endcase
  end

  // Load data: shift the addressed lane down, then extend per latched size/unsigned
  always_comb begin
    lane_c = rdata >> {off_q, 3'b000};
    ext_c  = lane_c;
    case (size_q)
      2'd0:    ext_c = {{24{~uns_q & lane_c[7]}}, lane_c[7:0]};
      2'd1:    ext_c = {{16{~uns_q & lane_c[15]}}, lane_c[15:0]};
      default: ext_c = lane_c;
    endcase
  end

  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      araddr_q     <= 32'd0;
      awaddr_q     <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic; a response in the timeout cycle takes priority
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign_c)   state_d = DONE;
          else if (req_wen) state_d = WRITE;
          else              state_d = READ;
        end
      end
      READ:    if (rvalid || timeout_hit_c) state_d = DONE;
      WRITE:   if (bvalid || timeout_hit_c) state_d = DONE;
      DONE:    if (resp_valid_q && resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request fields
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    ren_d        = ren_q;
    wen_d        = wen_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          cnt_d  = '0;
          if (misalign_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_wen) begin
            wen_d    = 1'b1;
            awaddr_d = {req_addr[31:2], 2'b00};
            wdata_d  = req_wdata << {req_addr[1:0], 3'b000};
            wstrb_d  = strb_c << req_addr[1:0];
          end else begin
            ren_d    = 1'b1;
            araddr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ: begin
        if (rvalid) begin
          ren_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (rresp != 2'b00);
          resp_rdata_d = (rresp != 2'b00) ? 32'd0 : ext_c;
        end else if (timeout_hit_c) begin
          ren_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        if (bvalid) begin
          wen_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (bresp != 2'b00);
          resp_rdata_d = 32'd0;
        end else if (timeout_hit_c) begin
          wen_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;
      end
      default: begin
        ren_d        = 1'b0;
        wen_d        = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign ren        = ren_q;
  assign wen        = wen_q;
  assign araddr     = araddr_q;
  assign awaddr     = awaddr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_24110015_mem_master.sv
// Scoreboard bench for ysyx_24110015_mem_master: directed requests push expected
// responses, a negedge monitor pops and compares them, a small memory model responds.
module tb_ysyx_24110015_mem_master;

  localparam int unsigned TMO = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        ren, rvalid, wen, bvalid;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  ysyx_24110015_mem_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .ren(ren), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
    .bresp(bresp), .bvalid(bvalid)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // cycle index of first resp_valid, cycle 1 = the one after the accept edge
    bit          mem;   // a memory request is expected
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // memory model configuration
  int          mem_delay = 5;
  bit          mem_silent = 0;
  logic [1:0]  mem_resp = 2'd0;
  logic [31:0] mem_word = 32'h8899AABB;
  int          mcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    else n_pass++;
  endtask

  // Memory: raises rvalid/bvalid so the DUT samples it mem_delay edges after acceptance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0; bvalid <= 1'b0; rdata <= 32'd0;
      rresp <= 2'd0; bresp <= 2'd0; mcnt <= 0;
    end else if (!ren && !wen) begin
      rvalid <= 1'b0; bvalid <= 1'b0; mcnt <= 0;
    end else if (!rvalid && !bvalid && !mem_silent) begin
      if (mcnt == mem_delay - 2) begin
        if (ren) begin rvalid <= 1'b1; rdata <= mem_word; rresp <= mem_resp; end
        else     begin bvalid <= 1'b1; bresp <= mem_resp; end
      end else mcnt <= mcnt + 1;
    end
  end

  // Monitor
  bit          seen, mem_seen;
  int          last_hs = -100;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_strb;
  bit          cap_wr;

  always @(negedge clk) begin
    if (rst) begin
      seen = 0; mem_seen = 0; last_hs = -100;
    end else begin
      if ((ren || wen) && !mem_seen) begin
        mem_seen = 1;
        cap_wr   = wen;
        cap_addr = wen ? awaddr : araddr;
        cap_wd   = wdata;
        cap_strb = wstrb;
        chk("req_spacing", (cyc - last_hs >= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("prev_resp_clear", {30'd0, rvalid, bvalid}, 32'd0);
      end
      if (mem_seen && ren) chk("araddr_stable", araddr, cap_addr);
      if (mem_seen && wen) chk("wdata_stable", wdata, cap_wd);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb[0];
          if (!seen) begin
            seen = 1;
            if (e.lat >= 0) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("ren_wen_low_done", {30'd0, ren, wen}, 32'd0);
          end
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
          if (resp_ready) begin
            chk("mem_issued", {31'd0, mem_seen}, {31'd0, e.mem});
            if (e.mem) begin
              chk("mem_dir", {31'd0, cap_wr}, {31'd0, e.wr});
              chk("mem_addr", cap_addr, e.addr);
              if (e.wr) begin
                chk("wdata", cap_wd, e.wd);
                chk("wstrb", {28'd0, cap_strb}, {28'd0, e.strb});
              end
            end
            void'(sb.pop_front());
            seen = 0; mem_seen = 0; last_hs = cyc;
          end
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns, input exp_t e_in, input bit push);
    exp_t e;
    int n;
    e = e_in; n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_wen = wr; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic err, input int lat,
                              input bit mem, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] strb);
    exp_t e;
    e.rdata = rd; e.err = err; e.lat = lat; e.mem = mem; e.wr = wr;
    e.addr = addr; e.wd = wd; e.strb = strb; e.acc = 0;
    return e;
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    bit any_rv;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ren_wen", {30'd0, ren, wen}, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", araddr | awaddr | wdata | {28'd0, wstrb}, 32'd0);
    rst = 1'b0;

    // Loads of 0x8899AABB with a 5-cycle memory
    issue(0, 32'h80000004, 0, 2'd2, 0, mk(32'h8899AABB, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000007, 0, 2'd0, 0, mk(32'hFFFFFF88, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000007, 0, 2'd0, 1, mk(32'h00000088, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000006, 0, 2'd1, 0, mk(32'hFFFF8899, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000004, 0, 2'd0, 0, mk(32'hFFFFFFBB, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000004, 0, 2'd1, 1, mk(32'h0000AABB, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();

    // Stores
    mem_delay = 2;
    issue(1, 32'h80000002, 32'h000000CD, 2'd0, 0,
          mk(32'd0, 0, 3, 1, 1, 32'h80000000, 32'h00CD0000, 4'b0100), 1);
    wait_done();
    mem_delay = 5;
    issue(1, 32'h80000002, 32'h0000BEEF, 2'd1, 0,
          mk(32'd0, 0, 6, 1, 1, 32'h80000000, 32'hBEEF0000, 4'b1100), 1);
    wait_done();
    mem_resp = 2'd2;
    issue(1, 32'h80000008, 32'h12345678, 2'd2, 0,
          mk(32'd0, 1, 6, 1, 1, 32'h80000008, 32'h12345678, 4'b1111), 1);
    wait_done();
    issue(0, 32'h80000004, 0, 2'd2, 0, mk(32'd0, 1, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    mem_resp = 2'd0;

    // Misaligned requests never reach memory
    issue(0, 32'h80000001, 0, 2'd2, 0, mk(32'd0, 1, 1, 0, 0, 0, 0, 0), 1);
    wait_done();
    issue(1, 32'h80000003, 32'h1111, 2'd1, 0, mk(32'd0, 1, 1, 0, 0, 0, 0, 0), 1);
    wait_done();
    issue(0, 32'h80000000, 0, 2'd3, 0, mk(32'd0, 1, 1, 0, 0, 0, 0, 0), 1);
    wait_done();

    // Silent memory: timeout after TMO cycles in READ and in WRITE
    mem_silent = 1;
    issue(0, 32'h80000010, 0, 2'd2, 0, mk(32'd0, 1, TMO + 1, 1, 0, 32'h80000010, 0, 0), 1);
    wait_done();
    issue(1, 32'h80000010, 32'hA5A5A5A5, 2'd2, 0,
          mk(32'd0, 1, TMO + 1, 1, 1, 32'h80000010, 32'hA5A5A5A5, 4'b1111), 1);
    wait_done();
    mem_silent = 0;

    // Back-to-back loads with the first response held off for 3 cycles
    resp_ready = 1'b0;
    issue(0, 32'h80000004, 0, 2'd2, 0, mk(32'h8899AABB, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    begin
      int n;
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
      if (!resp_valid) chk("hold_wait", {31'd0, resp_valid}, 32'd1);
    end
    repeat (3) @(negedge clk);
    resp_ready = 1'b1;
    issue(0, 32'h80000005, 0, 2'd0, 1, mk(32'h000000AA, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();

    // Reset in the middle of a read abandons it
    mem_silent = 1;
    issue(0, 32'h80000004, 0, 2'd2, 0, mk(32'd0, 0, -1, 1, 0, 0, 0, 0), 0);
    repeat (2) @(negedge clk);
    chk("ren_before_rst", {31'd0, ren}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ren_async_rst", {31'd0, ren}, 32'd0);
    chk("resp_valid_async_rst", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_silent = 0;
    any_rv = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || ren) any_rv = 1;
    end
    chk("no_resp_after_rst", {31'd0, any_rv}, 32'd0);

    // Normal operation after reset
    issue(0, 32'h80000006, 0, 2'd1, 1, mk(32'h00008899, 0, 6, 1, 0, 32'h80000004, 0, 0), 1);
    wait_done();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
